// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate byte cache.
// 8 lines of 4 bytes; tag = ADDRESS[7:5], index = ADDRESS[4:2], offset = ADDRESS[1:0].
// Hits are served combinationally. Misses run an optional WRITEBACK of the dirty victim,
// then a FETCH of the requested block, and then return to IDLE where the held request hits.
module dcache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FETCH
    } state_t;

    state_t state_reg;
    logic   mem_read_reg;
    logic   mem_write_reg;

    // Address fields of the current CPU request
    logic [2:0] tag_in;
    logic [2:0] index;
    logic [1:0] offset;

    assign tag_in = ADDRESS[7:5];
    assign index  = ADDRESS[4:2];
    assign offset = ADDRESS[1:0];

    // Per-line storage gathered into vectors so the indexed line can be selected
    logic [7:0]  valid_vec;
    logic [7:0]  dirty_vec;
    logic [2:0]  tag_vec  [8];
    logic [31:0] data_vec [8];

    logic request;
    logic hit;
    logic write_hit_en;
    logic fill_en;

    assign request = READ | WRITE;
    assign hit     = valid_vec[index] && (tag_vec[index] == tag_in);

    // A write hit updates the line only while IDLE; a refill lands when memory finishes
    assign write_hit_en = (state_reg == ST_IDLE) && WRITE && hit;
    assign fill_en      = (state_reg == ST_FETCH) && !MEM_BUSYWAIT;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            logic        valid_reg;
            logic        dirty_reg;
            logic [2:0]  tag_reg;
            logic [31:0] data_reg;
            logic        sel;

            assign sel = (index == 3'(gi));

            // Line update: reset clears valid/dirty, refill loads a clean block, write hit patches a byte
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    valid_reg <= 1'b0;
                    dirty_reg <= 1'b0;
                end else if (sel && fill_en) begin
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                    tag_reg   <= tag_in;
                    data_reg  <= MEM_READDATA;
                end else if (sel && write_hit_en) begin
                    dirty_reg <= 1'b1;
                    data_reg[{offset, 3'b000} +: 8] <= WRITEDATA;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign dirty_vec[gi] = dirty_reg;
            assign tag_vec[gi]   = tag_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    // Miss handling FSM; memory strobes are registered alongside the state they belong to
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (request && !hit) begin
                        if (valid_vec[index] && dirty_vec[index]) begin
                            state_reg     <= ST_WRITEBACK;
                            mem_write_reg <= 1'b1;
                        end else begin
                            state_reg     <= ST_FETCH;
                            mem_read_reg  <= 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_reg     <= ST_FETCH;
                        mem_write_reg <= 1'b0;
                        mem_read_reg  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (!MEM_BUSYWAIT) begin
                        state_reg    <= ST_IDLE;
                        mem_read_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                end
            endcase
        end
    end

    assign MEM_READ      = mem_read_reg;
    assign MEM_WRITE     = mem_write_reg;
    // The victim's stored tag addresses the writeback; fetches use the request address
    assign MEM_ADDRESS   = (state_reg == ST_WRITEBACK) ? {tag_vec[index], index} : ADDRESS[7:2];
    assign MEM_WRITEDATA = data_vec[index];

    assign READDATA = data_vec[index][{offset, 3'b000} +: 8];
    assign BUSYWAIT = !RESET && request && ((state_reg != ST_IDLE) || !hit);

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed scenarios plus randomized byte traffic, checked against a
// line-level behavioural model of the cache and a simple word-addressed memory.
module tb_dcache;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    dcache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cache lines and backing memory
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] mem     [64];
    int          mem_lat = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // Memory responder: random latency per transfer, completion seen at the next posedge
    task automatic mem_respond();
        if (MEM_READ || MEM_WRITE) begin
            if (mem_lat < 0) mem_lat = $urandom_range(0, 3);
            if (mem_lat == 0) begin
                MEM_BUSYWAIT = 1'b0;
                if (MEM_READ) MEM_READDATA = mem[MEM_ADDRESS];
                mem_lat = -1;
            end else begin
                MEM_BUSYWAIT = 1'b1;
                mem_lat--;
            end
        end else begin
            MEM_BUSYWAIT = 1'b0;
            mem_lat = -1;
        end
    endtask

    // One CPU access, started on a negedge; returns on the negedge after it completes
    task automatic do_access(input bit rd, input logic [7:0] addr, input logic [7:0] wd);
        logic [2:0]  idx;
        logic [2:0]  tg;
        logic [1:0]  off;
        bit          exp_hit;
        bit          exp_wb;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] line;
        bit          wb_seen;
        bit          fe_seen;
        bit          done;
        bit          first;

        idx     = addr[4:2];
        tg      = addr[7:5];
        off     = addr[1:0];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
        wb_addr = {m_tag[idx], idx};
        wb_data = m_data[idx];
        line    = exp_hit ? m_data[idx] : mem[addr[7:2]];

        READ = rd;
        WRITE = !rd;
        ADDRESS = addr;
        WRITEDATA = wd;
        wb_seen = 0;
        fe_seen = 0;
        done = 0;
        first = 1;

        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (first) begin
                check("busywait_first", {31'd0, BUSYWAIT}, {31'd0, !exp_hit});
                first = 0;
            end
            if (!BUSYWAIT) begin
                if (rd) check("readdata", {24'd0, READDATA}, {24'd0, line[8*off +: 8]});
                check("mem_idle_at_done", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
                done = 1;
            end else begin
                if (MEM_READ && MEM_WRITE) check("mem_rd_wr_both", 32'd1, 32'd0);
                if (MEM_WRITE && !wb_seen) begin
                    check("wb_addr", {26'd0, MEM_ADDRESS}, {26'd0, wb_addr});
                    check("wb_data", MEM_WRITEDATA, wb_data);
                    wb_seen = 1;
                end
                if (MEM_READ && !fe_seen) begin
                    check("fetch_addr", {26'd0, MEM_ADDRESS}, {26'd0, addr[7:2]});
                    check("fetch_after_wb", {31'd0, wb_seen}, {31'd0, exp_wb});
                    fe_seen = 1;
                end
            end
            mem_respond();
            @(posedge CLK);
            @(negedge CLK);
        end
        if (!done) check("access_timeout", 32'd1, 32'd0);
        check("wb_seen", {31'd0, wb_seen}, {31'd0, exp_wb});
        check("fetch_seen", {31'd0, fe_seen}, {31'd0, !exp_hit});
        READ = 1'b0;
        WRITE = 1'b0;

        if (exp_wb) mem[wb_addr] = wb_data;
        m_valid[idx] = 1'b1;
        m_tag[idx] = tg;
        if (!exp_hit) m_dirty[idx] = 1'b0;
        if (!rd) begin
            line[8*off +: 8] = wd;
            m_dirty[idx] = 1'b1;
        end
        m_data[idx] = line;
        $display("access %s addr=%02h wdata=%02h hit=%0d wb=%0d rdata=%02h", rd ? "RD" : "WR",
                 addr, wd, exp_hit, exp_wb, READDATA);
    endtask

    initial begin
        logic [7:0] a;
        RESET = 1'b1;
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 8'h00;
        WRITEDATA = 8'h00;
        MEM_READDATA = 32'h0;
        MEM_BUSYWAIT = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;
        model_reset();

        // Reset with a pending request: stall is suppressed and no memory activity follows
        @(negedge CLK);
        #1;
        check("busywait_in_reset", {31'd0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        #1;
        check("reset_mem_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        READ = 1'b0;
        #1;
        check("post_reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
        check("post_reset_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        @(negedge CLK);

        // Clean miss, hit, write hit, read-back, dirty eviction, write-allocate
        do_access(1, 8'h00, 8'h00);
        do_access(1, 8'h03, 8'h00);
        do_access(0, 8'h01, 8'hAB);
        do_access(1, 8'h01, 8'h00);
        do_access(1, 8'h20, 8'h00);
        do_access(0, 8'h45, 8'h7E);
        do_access(1, 8'h45, 8'h00);
        do_access(1, 8'h05, 8'h00);

        // Reset in the middle of a fetch drops the transfer and invalidates the cache
        do_access(1, 8'h00, 8'h00);
        READ = 1'b1;
        ADDRESS = 8'h1C;
        MEM_BUSYWAIT = 1'b1;
        #1;
        check("rst_mid_miss_busy", {31'd0, BUSYWAIT}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("rst_mid_fetch_active", {30'd0, MEM_READ, MEM_WRITE}, 32'd2);
        RESET = 1'b1;
        #1;
        check("rst_forces_busywait", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rst_mid_fetch_idle", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
        READ = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        mem_lat = -1;
        model_reset();
        @(negedge CLK);
        do_access(1, 8'h00, 8'h00);

        // No request: no stall and no memory traffic for any address
        for (int i = 0; i < 256; i++) begin
            a = 8'(i);
            ADDRESS = a;
            #1;
            check("idle_busywait", {31'd0, BUSYWAIT}, 32'd0);
            check("idle_mem_strobes", {30'd0, MEM_READ, MEM_WRITE}, 32'd0);
            @(negedge CLK);
        end

        // Randomized traffic biased towards two tags so hits, conflicts and evictions mix
        for (int t = 0; t < 250; t++) begin
            bit rd;
            rd = ($urandom % 2) == 0;
            a = {3'($urandom_range(0, 1) * 3), 3'($urandom % 8), 2'($urandom % 4)};
            do_access(rd, a, 8'($urandom));
            if (($urandom % 4) == 0) @(negedge CLK);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
